// File: rtl/video_pkg.sv
// Shared video-pipeline types for the overlay controller.
//   rgb_t        : 24-bit colour, R[23:16] G[15:8] B[7:0]
//   coord_t      : coordinate container, wide enough for any supported CW
//   ovl_region_t : one overlay region (enable, inclusive bounds, colour)
package video_pkg;

  localparam int unsigned OVL_MAX_REGIONS = 8;
  // Coordinates are stored zero-extended to this width; CW must not exceed it.
  localparam int unsigned OVL_MAX_CW      = 16;

  typedef logic [23:0]           rgb_t;
  typedef logic [OVL_MAX_CW-1:0] coord_t;

  typedef struct packed {
    logic   en;
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
    rgb_t   rgb;
  } ovl_region_t;

endpackage

// File: rtl/ovl_region_match.sv
// Combinational hit test of one overlay region against the current pixel.
//   region_i : region descriptor (active table entry)
//   x_i, y_i : current pixel coordinates, zero-extended
//   blank_i  : {Vblank, Hblank}; any blank suppresses the hit
//   hit_o    : region covers the pixel
module ovl_region_match
  import video_pkg::*;
(
  input  ovl_region_t region_i,
  input  coord_t      x_i,
  input  coord_t      y_i,
  input  logic [1:0]  blank_i,
  output logic        hit_o
);

  // Inverted bounds (x0 > x1 or y0 > y1) fail one of the compares on their own.
  assign hit_o = region_i.en & ~(|blank_i) &
                 (region_i.x0 <= x_i) & (x_i <= region_i.x1) &
                 (region_i.y0 <= y_i) & (y_i <= region_i.y1);

endmodule

// File: rtl/ovl_region_ctrl.sv
// Raster-tracking overlay controller. Recovers pixel position from the blank
// signals, holds a double-buffered table of overlay regions that commits at
// vertical-blank start, and emits a registered per-pixel hit/index/colour.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cen_i               : video clock enable (gates all state but the cfg port)
//   vh_blank_i          : {Vblank, Hblank}
//   cfg_*               : region write handshake into the shadow table
//   hcount_o, vcount_o  : coordinates of the pixel presented one cen earlier
//   ovl_hit_o/idx_o/rgb_o : winning region for that pixel (0 when no hit)
//   frame_o             : frame counter, steps on Vblank rise
//   cfg_pending_o       : shadow table holds uncommitted writes
module ovl_region_ctrl
  import video_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned CW          = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cen_i,
  input  logic [1:0]    vh_blank_i,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [2:0]    cfg_idx_i,
  input  logic          cfg_en_i,
  input  logic [CW-1:0] cfg_x0_i,
  input  logic [CW-1:0] cfg_x1_i,
  input  logic [CW-1:0] cfg_y0_i,
  input  logic [CW-1:0] cfg_y1_i,
  input  logic [23:0]   cfg_rgb_i,
  output logic [CW-1:0] hcount_o,
  output logic [CW-1:0] vcount_o,
  output logic          ovl_hit_o,
  output logic [2:0]    ovl_idx_o,
  output logic [23:0]   ovl_rgb_o,
  output logic [7:0]    frame_o,
  output logic          cfg_pending_o
);

  logic          h_q, v_q;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          dirty_q;
  logic [7:0]    frame_q;
  logic [CW-1:0] hcount_q, vcount_q;
  logic          hit_q;
  logic [2:0]    idx_q;
  rgb_t          rgb_q;

  ovl_region_t   shadow_q [NUM_REGIONS];
  ovl_region_t   active_q [NUM_REGIONS];

  logic hfall, hrise, vfall, vrise;
  logic commit, cfg_wr, idx_ok;
  logic [NUM_REGIONS-1:0] wr_sel, hit_vec;
  ovl_region_t   new_entry;
  coord_t        x_ext, y_ext;
  logic          win_hit;
  logic [2:0]    win_idx;
  rgb_t          win_rgb;

  assign hfall = ~vh_blank_i[0] & h_q;
  assign hrise =  vh_blank_i[0] & ~h_q;
  assign vfall = ~vh_blank_i[1] & v_q;
  assign vrise =  vh_blank_i[1] & ~v_q;

  always_comb begin
    hcnt_d = hfall ? '0 : hcnt_q + 1'b1;
    if (vfall) begin
      vcnt_d = '0;
    end else if (hrise && !vh_blank_i[1]) begin
      vcnt_d = vcnt_q + 1'b1;
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // Ready drops only in the commit cycle so a write can never land mid-copy.
  assign commit      = cen_i & vrise & dirty_q;
  assign cfg_ready_o = ~commit;
  assign cfg_wr      = cfg_valid_i & cfg_ready_o;

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      wr_sel[i] = (cfg_idx_i == 3'(i));
    end
  end
  // Writes to indices beyond the table are accepted but leave no trace.
  assign idx_ok = |wr_sel;

  assign new_entry = '{en:  cfg_en_i,
                       x0:  coord_t'(cfg_x0_i),
                       x1:  coord_t'(cfg_x1_i),
                       y0:  coord_t'(cfg_y0_i),
                       y1:  coord_t'(cfg_y1_i),
                       rgb: cfg_rgb_i};

  assign x_ext = coord_t'(hcnt_d);
  assign y_ext = coord_t'(vcnt_d);

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    ovl_region_match u_match (
      .region_i (active_q[g]),
      .x_i      (x_ext),
      .y_i      (y_ext),
      .blank_i  (vh_blank_i),
      .hit_o    (hit_vec[g])
    );
  end

  // Lowest matching index wins.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_rgb = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (hit_vec[i] && !win_hit) begin
        win_hit = 1'b1;
        win_idx = 3'(i);
        win_rgb = active_q[i].rgb;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q      <= 1'b0;
      v_q      <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      dirty_q  <= 1'b0;
      frame_q  <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      rgb_q    <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (cen_i) begin
        h_q      <= vh_blank_i[0];
        v_q      <= vh_blank_i[1];
        hcnt_q   <= hcnt_d;
        vcnt_q   <= vcnt_d;
        hcount_q <= hcnt_d;
        vcount_q <= vcnt_d;
        hit_q    <= win_hit;
        idx_q    <= win_idx;
        rgb_q    <= win_rgb;
        if (vrise) frame_q <= frame_q + 8'd1;
      end
      if (commit) begin
        for (int i = 0; i < NUM_REGIONS; i++) active_q[i] <= shadow_q[i];
      end
      if (cfg_wr) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (wr_sel[i]) shadow_q[i] <= new_entry;
        end
      end
      if (commit) begin
        dirty_q <= 1'b0;
      end else if (cfg_wr && idx_ok) begin
        dirty_q <= 1'b1;
      end
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign ovl_hit_o     = hit_q;
  assign ovl_idx_o     = idx_q;
  assign ovl_rgb_o     = rgb_q;
  assign frame_o       = frame_q;
  assign cfg_pending_o = dirty_q;

endmodule
